load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one memory operation at a time over a simple valid/ready bus.
// Define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors without bus traffic.

package common;
  localparam logic [3:0] LB  = 4'h0;
  localparam logic [3:0] LH  = 4'h1;
  localparam logic [3:0] LW  = 4'h2;
  localparam logic [3:0] LBU = 4'h4;
  localparam logic [3:0] LHU = 4'h5;
  localparam logic [3:0] SB  = 4'h8;
  localparam logic [3:0] SH  = 4'h9;
  localparam logic [3:0] SW  = 4'hA;

  function automatic logic is_load(input logic [3:0] t);
    return t inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(input logic [3:0] t);
    return t inside {SB, SH, SW};
  endfunction
endpackage

module load_store_unit #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  access_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  import common::*;

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    type_q, type_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          timeout;
  logic          misaligned;
  logic [1:0]    off;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;
  logic [31:0]   lane_wdata;
  logic [3:0]    lane_wstrb;

  assign off     = addr_q[1:0];
  assign timeout = (cnt_q == CW'(BUS_TIMEOUT));

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (access_type)
      LH, LHU, SH: misaligned = addr[0];
      LW, SW:      misaligned = |addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Lane extraction always works on the captured address, never the live request port.
  always_comb begin
    byte_sel = mem_rdata[{off, 3'b000} +: 8];
    half_sel = mem_rdata[{off[1], 4'b0000} +: 16];
    case (type_q)
      LB:      load_ext = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_ext = {24'h0, byte_sel};
      LH:      load_ext = {{16{half_sel[15]}}, half_sel};
      LHU:     load_ext = {16'h0, half_sel};
      LW:      load_ext = mem_rdata;
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    case (type_q)
      SB: begin
        lane_wdata = {4{wdata_q[7:0]}};
        lane_wstrb = 4'b0001 << off;
      end
      SH: begin
        lane_wdata = {2{wdata_q[15:0]}};
        lane_wstrb = 4'b0011 << {off[1], 1'b0};
      end
      SW: begin
        lane_wdata = wdata_q;
        lane_wstrb = 4'hF;
      end
      default: begin
        lane_wdata = '0;
        lane_wstrb = '0;
      end
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          type_d  = access_type;
          addr_d  = addr;
          wdata_d = wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (!(is_load(access_type) || is_store(access_type))) begin
            state_d = S_RESP;
          end else if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (mem_ready) state_d = is_store(type_q) ? S_RESP : S_RDATA;
        end
      end
      S_RDATA: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

  // The bus request is withdrawn in the cycle the wait budget runs out.
  assign mem_valid  = (state_q == S_REQ) && !timeout;
  assign mem_wen    = mem_valid && is_store(type_q);
  assign mem_ren    = mem_valid && is_load(type_q);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = lane_wdata;
  assign mem_wstrb  = lane_wstrb;

endmodule
